// File: rtl/dmem_responder_if.sv
// DMEM port bundle between the core (master) and the data memory (slave).
// Latency: none (wires only).
// Backpressure: the memory reports mem_busy/mem_ready; the core holds its request until mem_ready.
//   address_DMEM, write_data_DMEM, byte_en, MemWrite, MemRead : core -> memory
//   data_DMEM, mem_ready, mem_busy                            : memory -> core
interface dmem_responder_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address_DMEM;
  logic [31:0]       write_data_DMEM;
  logic [3:0]        byte_en;
  logic              MemWrite;
  logic              MemRead;
  logic [31:0]       data_DMEM;
  logic              mem_ready;
  logic              mem_busy;

  modport master (
    output address_DMEM, write_data_DMEM, byte_en, MemWrite, MemRead,
    input  data_DMEM, mem_ready, mem_busy
  );

  modport slave (
    input  address_DMEM, write_data_DMEM, byte_en, MemWrite, MemRead,
    output data_DMEM, mem_ready, mem_busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 2^ADDR_W x 32-bit word array with byte write enables behind a ready/busy handshake.
// Latency: write completes (mem_ready) 1 cycle after acceptance; read completes READ_LATENCY (1..7) cycles after acceptance.
// Backpressure: mem_busy is high while a request is in flight; requests seen while busy are ignored.
// Ports: CLK, RST (async, active-high); bus (dmem_responder_if.slave) carrying the DMEM request/response;
//   leds[7:0] exists only when DMEM_MMIO_EN is defined. With DMEM_MMIO_EN the top word address is a
//   read-only free-running cycle counter and the one below it is the LED register.
module dmem_responder #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic            CLK,
  input  logic            RST,
  dmem_responder_if.slave bus
`ifdef DMEM_MMIO_EN
  ,
  output logic [7:0]      leds
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              mmio_sel_q;
  logic [31:0]       mmio_val_q;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              accept_wr;
  logic              accept_rd;
  logic              ram_we;
  logic              mmio_hit;
  logic [31:0]       mmio_val;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_word;

  // A write whose accepting edge sees RST high must not reach the array, which has
  // no reset of its own; qualifying here keeps that out of the array process.
  // A simultaneous read is dropped in favour of the write.
  assign accept_wr = (state == IDLE) && bus.MemWrite && !RST;
  assign accept_rd = (state == IDLE) && bus.MemRead && !bus.MemWrite;

  // Single array read port: the live address when a one-cycle read completes at
  // acceptance, otherwise the address latched when the read was accepted.
  assign rd_addr = (state == IDLE) ? bus.address_DMEM : raddr;
  assign rd_word = mem[rd_addr];

`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_W-1:0] CNT_ADDR = '1;
  localparam logic [ADDR_W-1:0] LED_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};

  logic [31:0] cyc_cnt;
  logic [7:0]  led_q;
  logic        hit_cnt;
  logic        hit_led;

  assign hit_cnt  = (bus.address_DMEM == CNT_ADDR);
  assign hit_led  = (bus.address_DMEM == LED_ADDR);
  assign mmio_hit = hit_cnt | hit_led;
  assign mmio_val = hit_cnt ? cyc_cnt : {24'd0, led_q};
  assign ram_we   = accept_wr && !mmio_hit;
  assign leds     = led_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_cnt <= '0;
      led_q   <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (accept_wr && hit_led && bus.byte_en[0])
        led_q <= bus.write_data_DMEM[7:0];
    end
  end
`else
  assign mmio_hit = 1'b0;
  assign mmio_val = '0;
  assign ram_we   = accept_wr;
`endif

  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byte_en[i])
          mem[bus.address_DMEM][8*i +: 8] <= bus.write_data_DMEM[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      raddr      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      mmio_sel_q <= 1'b0;
      mmio_val_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_wr) begin
            state   <= RESP;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (accept_rd) begin
            raddr      <= bus.address_DMEM;
            // MMIO values are captured at acceptance so the counter reads as of this edge.
            mmio_sel_q <= mmio_hit;
            mmio_val_q <= mmio_val;
            busy_q     <= 1'b1;
            if (READ_LATENCY == 1) begin
              rdata_q <= mmio_hit ? mmio_val : rd_word;
              lat_cnt <= '0;
              ready_q <= 1'b1;
              state   <= RESP;
            end else begin
              lat_cnt <= 3'(READ_LATENCY - 1);
              ready_q <= 1'b0;
              state   <= WAIT;
            end
          end else begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        WAIT: begin
          // lat_cnt holds the WAIT cycles still to run including this one; the
          // read finishes on the edge where it counts down to zero.
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            rdata_q <= mmio_sel_q ? mmio_val_q : rd_word;
            ready_q <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_DMEM = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: fixed vector table, reset/MMIO corner sequences, random traffic vs a byte-level model.
// Latency: checks cycle-exact mem_busy/mem_ready timing for every transaction.
// Backpressure: the bench acts as the core, holding each request until mem_ready and dropping it the cycle after.
module tb_dmem_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dmem_responder_if #(.ADDR_W(AW)) bus ();
`ifdef DMEM_MMIO_EN
  logic [7:0] leds;
`endif

  dmem_responder #(.ADDR_W(AW), .READ_LATENCY(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef DMEM_MMIO_EN
    ,
    .leds(leds)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;      // what data_DMEM should be holding
  logic [7:0]  mb [int];     // reference memory, one entry per byte address

  typedef struct {
    bit          wr;
    bit          rd;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;        // expected data_DMEM at completion
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.MemWrite        = 1'b0;
    bus.MemRead         = 1'b0;
    bus.address_DMEM    = '0;
    bus.write_data_DMEM = '0;
    bus.byte_en         = '0;
  endtask

  // One full transaction from the bench's acceptance cycle to the first idle cycle after it.
  task automatic run_op(input bit wr, input bit rd, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit chk, input logic [31:0] exp,
                        output logic [31:0] got);
    int lat;
    lat = wr ? 1 : LAT;
    bus.MemWrite        = wr;
    bus.MemRead         = rd;
    bus.address_DMEM    = a;
    bus.write_data_DMEM = wd;
    bus.byte_en         = be;
    check("busy_before_accept", bus.mem_busy, 1'b0);
    for (int j = 1; j <= lat; j++) begin
      tick();
      check($sformatf("busy_c%0d", j), bus.mem_busy, 1'b1);
      check($sformatf("ready_c%0d", j), bus.mem_ready, (j == lat) ? 1'b1 : 1'b0);
    end
    got = bus.data_DMEM;
    if (chk) check("data_at_ready", got, exp);
    idle_inputs();
    tick();
    check("busy_after", bus.mem_busy, 1'b0);
    check("ready_after", bus.mem_ready, 1'b0);
    check("data_hold", bus.data_DMEM, got);
    if (rd && !wr) last_rd = got;
  endtask

  task automatic model_wr(input logic [9:0] a, input logic [31:0] wd, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) mb[int'(a) * 4 + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_rd(input logic [9:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = mb.exists(int'(a) * 4 + i) ? mb[int'(a) * 4 + i] : 8'hxx;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] got, v1, v2, exp;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    int kind;

    tbl[0]  = '{1'b1, 1'b0, 10'd5, 32'hDEADBEEF, 4'b1111, 32'h00000000};
    tbl[1]  = '{1'b0, 1'b1, 10'd5, 32'h00000000, 4'b0000, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 10'd5, 32'h0000AB00, 4'b0010, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 10'd5, 32'h00000000, 4'b0101, 32'hDEADABEF};
    tbl[4]  = '{1'b1, 1'b1, 10'd7, 32'h12345678, 4'b1111, 32'hDEADABEF};
    tbl[5]  = '{1'b0, 1'b1, 10'd7, 32'h00000000, 4'b0000, 32'h12345678};
    tbl[6]  = '{1'b1, 1'b0, 10'd9, 32'h11223344, 4'b1111, 32'h12345678};
    tbl[7]  = '{1'b1, 1'b0, 10'd9, 32'hFFFFFFFF, 4'b0000, 32'h12345678};
    tbl[8]  = '{1'b0, 1'b1, 10'd9, 32'h00000000, 4'b0000, 32'h11223344};
    tbl[9]  = '{1'b1, 1'b0, 10'd9, 32'hAABBCCDD, 4'b1001, 32'h11223344};
    tbl[10] = '{1'b0, 1'b1, 10'd9, 32'h00000000, 4'b1111, 32'hAA2233DD};
    tbl[11] = '{1'b0, 1'b1, 10'd5, 32'h00000000, 4'b0000, 32'hDEADABEF};

    // Reset state
    RST = 1'b1;
    idle_inputs();
    repeat (2) tick();
    check("rst_data", bus.data_DMEM, 32'h0);
    check("rst_ready", bus.mem_ready, 1'b0);
    check("rst_busy", bus.mem_busy, 1'b0);
`ifdef DMEM_MMIO_EN
    check("rst_leds", leds, 8'h00);
`endif
    RST = 1'b0;
    last_rd = 32'h0;
    tick();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].be, 1'b1, tbl[i].exp, got);
      if (tbl[i].rd && !tbl[i].wr) last_rd = tbl[i].exp;
    end

    // Reset while a read is in WAIT: no completion, outputs cleared
    bus.MemRead = 1'b1;
    bus.address_DMEM = 10'd5;
    tick();
    check("wait_busy", bus.mem_busy, 1'b1);
    RST = 1'b1;
    #1;
    check("midrst_busy", bus.mem_busy, 1'b0);
    check("midrst_ready", bus.mem_ready, 1'b0);
    check("midrst_data", bus.data_DMEM, 32'h0);
    tick();
    RST = 1'b0;
    idle_inputs();
    last_rd = 32'h0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("no_ready_after_rst", bus.mem_ready, 1'b0);
    end
    run_op(1'b0, 1'b1, 10'd5, 32'h0, 4'h0, 1'b1, 32'hDEADABEF, got);

    // A write presented while RST is high is not performed
    RST = 1'b1;
    bus.MemWrite = 1'b1;
    bus.address_DMEM = 10'd5;
    bus.write_data_DMEM = 32'h0;
    bus.byte_en = 4'hF;
    tick();
    RST = 1'b0;
    idle_inputs();
    last_rd = 32'h0;
    tick();
    run_op(1'b0, 1'b1, 10'd5, 32'h0, 4'h0, 1'b1, 32'hDEADABEF, got);

`ifdef DMEM_MMIO_EN
    bus.MemWrite = 1'b1;
    bus.address_DMEM = 10'd1022;
    bus.write_data_DMEM = 32'h000000A5;
    bus.byte_en = 4'b0001;
    tick();
    check("led_wr_ready", bus.mem_ready, 1'b1);
    check("leds_next_cycle", leds, 8'hA5);
    idle_inputs();
    tick();
    run_op(1'b0, 1'b1, 10'd1022, 32'h0, 4'h0, 1'b1, 32'h000000A5, got);
    run_op(1'b1, 1'b0, 10'd1022, 32'h0000003C, 4'b1110, 1'b1, last_rd, got);
    check("leds_be0_clear", leds, 8'hA5);
    run_op(1'b0, 1'b1, 10'd1023, 32'h0, 4'h0, 1'b0, 32'h0, v1);
    repeat (7) tick();
    run_op(1'b0, 1'b1, 10'd1023, 32'h0, 4'h0, 1'b0, 32'h0, v2);
    check("cnt_delta", v2 - v1, 32'd10);
`else
    run_op(1'b1, 1'b0, 10'd1023, 32'hFFFFFFFF, 4'hF, 1'b1, last_rd, got);
    run_op(1'b0, 1'b1, 10'd1023, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF, got);
    run_op(1'b1, 1'b0, 10'd1022, 32'h0BADF00D, 4'hF, 1'b1, last_rd, got);
    run_op(1'b0, 1'b1, 10'd1022, 32'h0, 4'h0, 1'b1, 32'h0BADF00D, got);
    run_op(1'b0, 1'b1, 10'd1023, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF, got);
`endif

    // Random traffic against the byte-level model
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      run_op(1'b1, 1'b0, 10'(100 + i), wd, 4'hF, 1'b1, last_rd, got);
      model_wr(10'(100 + i), wd, 4'hF);
    end
    for (int n = 0; n < 60; n++) begin
      a    = 10'(100 + $urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      if (kind == 0) begin
        exp = model_rd(a);
        run_op(1'b0, 1'b1, a, wd, be, 1'b1, exp, got);
      end else begin
        run_op(1'b1, kind == 3, a, wd, be, 1'b1, last_rd, got);
        model_wr(a, wd, be);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the core's DMEM port: the memory side of the `address_DMEM` / `write_data_DMEM` / `MemWrite` / `MemRead` / `data_DMEM` interface.

- Holds a 2^ADDR_W x 32-bit word array with per-byte write enables.
- Adds a ready/busy handshake with configurable read latency, so the core can move to multi-cycle memory.
- Optionally maps a cycle counter and an LED register into the top two word addresses.

## Interface
Parameters:
- ADDR_W, 10, word-address width (matches `address_DMEM`).
- READ_LATENCY, 2, cycles from read acceptance to `mem_ready`; legal range 1..7.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- address_DMEM  in  ADDR_W  word address.
- write_data_DMEM  in  32  write data.
- byte_en  in  4  byte write enables; bit i writes bits [8i+7:8i].
- MemWrite  in  1  write request.
- MemRead  in  1  read request.
- data_DMEM  out  32  registered read data; holds the last completed read.
- mem_ready  out  1  one-cycle completion pulse for the accepted request.
- mem_busy  out  1  high while a request is in flight; new requests are not accepted.
- leds  out  8  LED register; present only with DMEM_MMIO_EN.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE.** A request is sampled when MemRead or MemWrite is high.
  - Write: the array is updated at that edge under byte_en, then go to RESP.
  - Read: latch the address, load the latency counter with READ_LATENCY-1, then go to WAIT (READ_LATENCY=1 goes straight to RESP).
- **WAIT.** Decrement the latency counter each cycle. At 0, load data_DMEM from the latched address and go to RESP.
- **RESP.** mem_ready=1 for exactly one cycle, then return to IDLE unconditionally.
- mem_busy=1 in WAIT and RESP, 0 in IDLE.
- Requests seen in WAIT or RESP are ignored.
- Initiator rules:
  - Hold the request and its address/data until mem_ready.
  - Deassert the cycle after mem_ready.
  - A request still high in the cycle after RESP is treated as a new request.
- Simultaneous MemRead and MemWrite in IDLE: the write is performed, the read is dropped, and data_DMEM is unchanged.
- byte_en=0000 with MemWrite: no array change, but still completes with mem_ready.
- Reads always return the full word and ignore byte_en.
- Array contents are not reset and are undefined until written.
- Reset values: state=IDLE, data_DMEM=0, mem_ready=0, mem_busy=0, latency counter=0, cycle counter=0, leds=0.
- Reset mid-operation:
  - A pending read is discarded and no mem_ready is produced.
  - A write whose accepting edge coincides with RST high is not performed.

## Timing
- Request high in IDLE during cycle k:
  - Write: array updated at end of k; mem_ready in k+1; mem_busy in k+1.
  - Read: mem_busy in k+1..k+READ_LATENCY; mem_ready and valid data_DMEM in k+READ_LATENCY.
- Maximum throughput:
  - Writes: one per 2 cycles.
  - Reads: one per READ_LATENCY+1 cycles.
- Read-after-write to the same address returns the new data; the write completes before the next acceptance.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `DMEM_MMIO_EN`.
- **Defined:**
  - Word address 2^ADDR_W-1 is a read-only cycle counter: 32 bits, +1 every cycle from reset, wraps 0xFFFFFFFF→0.
    - The read value is the counter at the acceptance edge.
    - Writes to it complete normally with no effect.
  - Word address 2^ADDR_W-2 is the LED register.
    - Writes load bits [7:0] when byte_en[0]=1.
    - Reads return {24'd0, leds}.
    - The leds output updates in the cycle after the write is accepted.
  - The array locations at these two addresses are unused.
- **Undefined:** no counter, no LED register, no leds port; all addresses are ordinary RAM.

## Test plan
- Write 0xDEADBEEF to addr 5, byte_en=1111, READ_LATENCY=2, then read addr 5 → write mem_ready at k+1; read mem_busy in k+1..k+2, mem_ready at k+2, data_DMEM=0xDEADBEEF.
- Write 0x0000AB00 to addr 5, byte_en=0010, then read addr 5 → 0xDEADABEF.
- MemRead=MemWrite=1 at addr 7 with data 0x12345678 → one mem_ready at k+1 and data_DMEM unchanged; subsequent read of addr 7 → 0x12345678.
- Read addr 5 accepted, then RST pulsed while in WAIT → no mem_ready, data_DMEM=0, mem_busy=0. A read after release completes normally with READ_LATENCY timing.
- With DMEM_MMIO_EN, write 0x000000A5 to addr 1022 → leds=0xA5 the next cycle, and a read of 1022 returns 0x000000A5. Reads of 1023 accepted 10 cycles apart → values differ by exactly 10.
- Without DMEM_MMIO_EN, write 0xFFFFFFFF to addr 1023, then read it → 0xFFFFFFFF. Addr 1022 also behaves as plain RAM.
